// File: rtl/ov7670_config_ctrl_pkg.sv
// ov7670_config_ctrl_pkg: shared state encoding and ROM constants for the OV7670 config controller
package ov7670_config_ctrl_pkg;
    localparam int ROM_AW = 8;
    localparam logic [15:0] END_MARKER = 16'hFFFF;
    localparam logic [15:0] DELAY_MARKER = 16'hFFF0;
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        DELAY,
        DONE
    } state_t;
endpackage

// File: rtl/ov7670_config_ctrl.sv
// ov7670_config_ctrl: walks a register ROM and issues one SCCB write per entry, honouring delay and end markers
module ov7670_config_ctrl
    import ov7670_config_ctrl_pkg::*;
#(
    parameter int DELAY_CYCLES = 500000,
    parameter logic [7:0] CAM_ID = 8'h42
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_start,
    output logic [7:0]        sccb_id,
    output logic [7:0]        sccb_addr,
    output logic [7:0]        sccb_data,
    input  logic              sccb_ready,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(DELAY_CYCLES + 1);

    state_t            state, state_next;
    logic [ROM_AW-1:0] addr_next, adv_addr;
    logic [CW-1:0]     count, count_next;
    logic [7:0]        reg_addr_next, reg_data_next;
    state_t            adv_state;

    assign sccb_id   = CAM_ID;
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = state == DONE;
    assign adv_state = (rom_addr == '1) ? DONE : FETCH;
    assign adv_addr  = (rom_addr == '1) ? rom_addr : rom_addr + ROM_AW'(1);

    // State, ROM address, delay counter and latched write fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rom_addr  <= '0;
            count     <= '0;
            sccb_addr <= '0;
            sccb_data <= '0;
        end else begin
            state     <= state_next;
            rom_addr  <= addr_next;
            count     <= count_next;
            sccb_addr <= reg_addr_next;
            sccb_data <= reg_data_next;
        end
    end

    // Next-state logic; sccb_start is a one-cycle Mealy pulse leaving SEND
    always_comb begin
        state_next    = state;
        addr_next     = rom_addr;
        count_next    = count;
        reg_addr_next = sccb_addr;
        reg_data_next = sccb_data;
        sccb_start    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = FETCH;
                    addr_next  = '0;
                end
            end
            FETCH: state_next = DECODE;
            DECODE: begin
                if (rom_data == END_MARKER) begin
                    state_next = DONE;
                end else if (rom_data == DELAY_MARKER) begin
                    state_next = DELAY;
                    count_next = CW'(DELAY_CYCLES - 1);
                end else begin
                    state_next    = SEND;
                    reg_addr_next = rom_data[15:8];
                    reg_data_next = rom_data[7:0];
                end
            end
            SEND: begin
                if (sccb_ready) begin
                    sccb_start = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: state_next = sccb_ready ? WAIT_ACK : WAIT_DONE;
            WAIT_DONE: begin
                if (sccb_ready) begin
                    state_next = adv_state;
                    addr_next  = adv_addr;
                end
            end
            DELAY: begin
                if (count == '0) begin
                    state_next = adv_state;
                    addr_next  = adv_addr;
                end else begin
                    count_next = count - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ov7670_config_ctrl.sv
// tb_ov7670_config_ctrl: table-driven and directed checks of the OV7670 config controller
module tb_ov7670_config_ctrl;
    typedef struct {
        string       nm;
        logic [15:0] w[4];
        int          exp_n;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [7:0]  e_addr;
        int          e_gap;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'h0;
    logic        sccb_start;
    logic [7:0]  sccb_id, sccb_addr, sccb_data;
    logic        sccb_ready = 1'b1;
    logic        busy, done;

    logic [15:0] rom [256];
    logic [15:0] w_ad [1024];
    int          w_cyc [1024];
    int          comp_cyc [1024];
    int          cyc = 0, busy_cnt = 0, n_w = 0, n_c = 0, multi = 0, unstable = 0;
    logic        prev_start = 1'b0, hold = 1'b0, chk_en = 1'b1;
    logic [15:0] last_w = 16'h0;
    int          nchk = 0, errs = 0;

    ov7670_config_ctrl #(.DELAY_CYCLES(20), .CAM_ID(8'h42)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb_start(sccb_start), .sccb_id(sccb_id), .sccb_addr(sccb_addr), .sccb_data(sccb_data),
        .sccb_ready(sccb_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Registered ROM: data valid one clock after the address
    always @(posedge clk) rom_data <= rom[rom_addr];

    // SCCB serialiser model and write logger
    always @(posedge clk) begin
        cyc <= cyc + 1;
        prev_start <= sccb_start;
        if (sccb_start && prev_start) multi <= multi + 1;
        if (chk_en && busy_cnt != 0 && {sccb_addr, sccb_data} != last_w) unstable <= unstable + 1;
        if (sccb_start) begin
            w_ad[n_w] <= {sccb_addr, sccb_data};
            w_cyc[n_w] <= cyc;
            n_w <= n_w + 1;
            last_w <= {sccb_addr, sccb_data};
        end
        if (hold) sccb_ready <= 1'b0;
        else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                sccb_ready <= 1'b1;
                comp_cyc[n_c] <= cyc;
                n_c <= n_c + 1;
            end
        end else if (sccb_start && sccb_ready) begin
            sccb_ready <= 1'b0;
            busy_cnt <= 10;
        end else sccb_ready <= 1'b1;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = a;
        rom[1] = b;
        rom[2] = c;
        rom[3] = d;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lim);
        bit ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check({nm, "_done_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[5];
        int   base, cbase, gap;
        bit   ok;
        v[0] = '{"plain",     '{16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF}, 2, 16'h1280, 16'h1100, 8'd2, 4};
        v[1] = '{"delay",     '{16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF}, 2, 16'h1280, 16'h1100, 8'd3, 26};
        v[2] = '{"empty",     '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 0, 16'h0000, 16'h0000, 8'd0, -1};
        v[3] = '{"lead_dly",  '{16'hFFF0, 16'h3A04, 16'hFFFF, 16'hFFFF}, 1, 16'h3A04, 16'h0000, 8'd2, -1};
        v[4] = '{"two_dly",   '{16'h1280, 16'hFFF0, 16'hFFF0, 16'hFFFF}, 1, 16'h1280, 16'h0000, 8'd3, -1};
        load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        check("rst_rom_addr", rom_addr, 8'h00);
        check("rst_sccb_start", sccb_start, 1'b0);
        check("rst_sccb_addr", sccb_addr, 8'h00);
        check("rst_sccb_data", sccb_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sccb_id", sccb_id, 8'h42);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 1'b0);
        for (int k = 0; k < 5; k++) begin
            load(v[k].w[0], v[k].w[1], v[k].w[2], v[k].w[3]);
            base = n_w;
            cbase = n_c;
            pulse_start();
            wait_done(v[k].nm, 2000);
            check({v[k].nm, "_writes"}, n_w - base, v[k].exp_n);
            check({v[k].nm, "_rom_addr"}, rom_addr, v[k].e_addr);
            check({v[k].nm, "_busy"}, busy, 1'b0);
            if (v[k].exp_n >= 1) check({v[k].nm, "_w0"}, w_ad[base], v[k].e0);
            if (v[k].exp_n >= 2) check({v[k].nm, "_w1"}, w_ad[base + 1], v[k].e1);
            if (v[k].e_gap >= 0) begin
                gap = w_cyc[base + 1] - comp_cyc[cbase];
                check({v[k].nm, "_gap"}, gap, v[k].e_gap);
            end
        end
        load(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        base = n_w;
        @(negedge clk);
        hold = 1'b1;
        pulse_start();
        repeat (50) @(negedge clk);
        check("hold_no_write", n_w - base, 0);
        check("hold_start_low", sccb_start, 1'b0);
        check("hold_busy", busy, 1'b1);
        check("hold_fields", {sccb_addr, sccb_data}, 16'h1280);
        hold = 1'b0;
        wait_done("hold", 2000);
        check("hold_writes", n_w - base, 1);
        check("hold_w0", w_ad[base], 16'h1280);
        load(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
        base = n_w;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_w - base == 1 && !sccb_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_mid_reach", {31'd0, ok}, 32'd1);
        @(negedge clk);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_rom_addr", rom_addr, 8'h00);
        check("rstmid_fields", {sccb_addr, sccb_data}, 16'h0000);
        check("rstmid_start", sccb_start, 1'b0);
        check("rstmid_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rstmid_no_more", n_w - base, 1);
        chk_en = 1'b1;
        pulse_start();
        wait_done("rstmid_rerun", 2000);
        check("rstmid_rerun_n", n_w - base, 3);
        check("rstmid_rerun_w0", w_ad[base + 1], 16'h1280);
        check("rstmid_rerun_w1", w_ad[base + 2], 16'h1100);
        base = n_w;
        pulse_start();
        repeat (8) @(negedge clk);
        check("ign_busy", busy, 1'b1);
        pulse_start();
        wait_done("ign", 2000);
        check("ign_writes", n_w - base, 2);
        base = n_w;
        pulse_start();
        wait_done("again", 2000);
        check("again_writes", n_w - base, 2);
        check("again_w0", w_ad[base], 16'h1280);
        check("again_w1", w_ad[base + 1], 16'h1100);
        for (int i = 0; i < 256; i++) rom[i] = {8'h01, 8'(i)};
        base = n_w;
        pulse_start();
        wait_done("full", 10000);
        check("full_writes", n_w - base, 256);
        check("full_rom_addr", rom_addr, 8'hFF);
        check("full_busy", busy, 1'b0);
        check("full_first", w_ad[base], 16'h0100);
        check("full_last", w_ad[base + 255], 16'h01FF);
        repeat (30) @(negedge clk);
        check("full_no_wrap_n", n_w - base, 256);
        check("full_no_wrap_addr", rom_addr, 8'hFF);
        check("full_done_held", done, 1'b1);
        check("single_pulse", multi, 0);
        check("fields_stable", unstable, 0);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule

// File: doc/ov7670_config_ctrl.md
OV7670_CONFIG_CTRL -- requirements
Module: ov7670_config_ctrl

Interface
REQ-001 Parameter DELAY_CYCLES, default 500000: clk cycles per ROM delay entry (10 ms at 50 MHz).
REQ-002 Parameter CAM_ID, default 8'h42: SCCB write ID passed through to the serialiser.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle request to run the configuration sequence.
REQ-006 rom_addr  output  8  address to the configuration ROM.
REQ-007 rom_data  input  16  ROM word {reg_addr[15:8], reg_value[7:0]}, valid one clk after rom_addr.
REQ-008 sccb_start  output  1  one-cycle write request to the SCCB serialiser.
REQ-009 sccb_id, sccb_addr, sccb_data  output  8 each  ID (=CAM_ID), register address, register value; held stable from sccb_start until sccb_ready returns high.
REQ-010 sccb_ready  input  1  serialiser idle; falls the cycle after an accepted sccb_start, rises on completion.
REQ-011 busy  output  1  high in every state except IDLE and DONE.
REQ-012 done  output  1  high in DONE until the next start.

Function
REQ-013 States: IDLE, FETCH, DECODE, SEND, WAIT_ACK, WAIT_DONE, DELAY, DONE.
REQ-014 IDLE/DONE + start -> FETCH with rom_addr=0; start while busy ignored.
REQ-015 FETCH: one cycle for registered ROM latency -> DECODE.
REQ-016 DECODE: rom_data==16'hFFFF -> DONE; ==16'hFFF0 -> DELAY with counter loaded DELAY_CYCLES-1; otherwise latch fields -> SEND.
REQ-017 SEND: if sccb_ready=1, assert sccb_start exactly one cycle -> WAIT_ACK; else stay.
REQ-018 WAIT_ACK: wait sccb_ready=0 -> WAIT_DONE; WAIT_DONE: wait sccb_ready=1 -> advance.
REQ-019 DELAY: decrement to zero, total exactly DELAY_CYCLES cycles in DELAY -> advance.
REQ-020 Advance: rom_addr==8'hFF -> DONE (no wrap); else rom_addr+1 -> FETCH.
REQ-021 Exactly one SCCB write per non-special ROM entry; special entries issue none.
REQ-022 Restart from DONE re-runs the full sequence from address 0.

Reset
REQ-023 rst_n low, asynchronously: state=IDLE, rom_addr=0, sccb_start=0, sccb_addr=0, sccb_data=0, counter=0, busy=0, done=0; sccb_id constant CAM_ID.
REQ-024 Reset mid-write aborts silently; no sccb_start issued until a new start after rst_n release.

Structure
REQ-025 Shared package: state encoding, END_MARKER=16'hFFFF, DELAY_MARKER=16'hFFF0, ROM address width 8.
REQ-026 Single module, no sub-modules; delay counter width $clog2(DELAY_CYCLES+1).

Verification
REQ-027 ROM {0x1280, 0x1100, FFFF}, auto-ack model (ready low 1 cycle after start, high 10 cycles later) -> two writes (12/80, 11/00), then done=1, busy=0, rom_addr=2.
REQ-028 ROM {0x1280, FFF0, 0x1100, FFFF}, DELAY_CYCLES=20 -> gap of >=20 cycles between first write completion and second sccb_start.
REQ-029 sccb_ready held low 50 cycles at SEND -> sccb_start stays 0 until ready rises, then one single-cycle pulse with 12/80 stable.
REQ-030 Reset pulse during WAIT_DONE of entry 1 -> outputs at reset values immediately; no further sccb_start; new start restarts at addr 0.
REQ-031 ROM of 256 non-special words -> 256 writes, rom_addr stops at 0xFF, done=1, no wrap to 0.
REQ-032 start pulsed while busy -> ignored; after done, start -> identical write sequence repeated.
